// File: rtl/spi_byte_master.sv
// spi_byte_master: byte-wide SPI master, mode 3 (CPOL=1, CPHA=1), MSB first.
// Accepts one byte per valid/ready handshake, drives one of two active-low
// selects, and returns the received byte with a one-cycle rx_valid strobe.
// The select can be held across bytes (tx_last=0) for multi-byte transactions.
module spi_byte_master #(
  parameter int CLKS_PER_HALF_BIT = 4,   // H, legal range 2..255
  parameter int CS_INACTIVE_CLKS  = 10   // deselect gap after a transaction; 0 acts as 1
) (
  input  logic       clk,
  input  logic       rst,                // asynchronous, active low
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  input  logic       tx_sel,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss1,
  output logic       ss2
);

  localparam int GAP_CLKS = (CS_INACTIVE_CLKS < 1) ? 1 : CS_INACTIVE_CLKS;
  localparam int GAP_BITS = $clog2(GAP_CLKS + 1);
  localparam int GAP_W    = (GAP_BITS > 8) ? GAP_BITS : 8;

  localparam logic [7:0]       HALF_LOAD = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state_reg,    state_next;
  logic [7:0]       half_cnt_reg, half_cnt_next;
  logic [2:0]       bit_cnt_reg,  bit_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg,  gap_cnt_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             last_reg,     last_next;
  logic             sclk_reg,     sclk_next;
  logic             mosi_reg,     mosi_next;
  logic             ss1_reg,      ss1_next;
  logic             ss2_reg,      ss2_next;
  logic             rx_valid_reg, rx_valid_next;
  logic [7:0]       rx_byte_reg,  rx_byte_next;
  logic             busy_reg,     busy_next;

  // State and every output-driving register; reset forces the idle bus
  // levels immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      half_cnt_reg <= 8'd0;
      bit_cnt_reg  <= 3'd0;
      gap_cnt_reg  <= '0;
      tx_shift_reg <= 8'd0;
      rx_shift_reg <= 8'd0;
      last_reg     <= 1'b0;
      sclk_reg     <= 1'b1;
      mosi_reg     <= 1'b1;
      ss1_reg      <= 1'b1;
      ss2_reg      <= 1'b1;
      rx_valid_reg <= 1'b0;
      rx_byte_reg  <= 8'd0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      half_cnt_reg <= half_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      last_reg     <= last_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      ss1_reg      <= ss1_next;
      ss2_reg      <= ss2_next;
      rx_valid_reg <= rx_valid_next;
      rx_byte_reg  <= rx_byte_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state and next-output decode; registers hold unless a state acts.
  always_comb begin
    state_next    = state_reg;
    half_cnt_next = half_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    last_next     = last_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    ss1_next      = ss1_reg;
    ss2_next      = ss2_reg;
    rx_valid_next = 1'b0;
    rx_byte_next  = rx_byte_reg;

    case (state_reg)
      IDLE: begin
        // Select choice is only taken here; the ss registers remember it.
        if (tx_valid) begin
          state_next    = SETUP;
          tx_shift_next = tx_byte;
          last_next     = tx_last;
          mosi_next     = tx_byte[7];
          ss1_next      = tx_sel;
          ss2_next      = ~tx_sel;
          half_cnt_next = HALF_LOAD;
        end
      end

      SETUP: begin
        // Select-to-first-edge setup; leaving it drives the first falling edge.
        if (half_cnt_reg == 8'd0) begin
          state_next    = SHIFT;
          sclk_next     = 1'b0;
          mosi_next     = tx_shift_reg[7];
          tx_shift_next = {tx_shift_reg[6:0], 1'b0};
          bit_cnt_next  = 3'd0;
          half_cnt_next = HALF_LOAD;
        end else begin
          half_cnt_next = half_cnt_reg - 8'd1;
        end
      end

      SHIFT: begin
        if (half_cnt_reg == 8'd0) begin
          half_cnt_next = HALF_LOAD;
          if (!sclk_reg) begin
            // End of low phase: rising edge, capture miso.
            sclk_next     = 1'b1;
            rx_shift_next = {rx_shift_reg[6:0], miso};
          end else if (bit_cnt_reg == 3'd7) begin
            // End of the eighth high phase: byte complete.
            rx_byte_next  = rx_shift_reg;
            rx_valid_next = 1'b1;
            half_cnt_next = 8'd0;
            if (last_reg) begin
              state_next   = GAP;
              ss1_next     = 1'b1;
              ss2_next     = 1'b1;
              mosi_next    = 1'b1;
              gap_cnt_next = GAP_LOAD;
            end else begin
              state_next = HOLD;
            end
          end else begin
            // End of a high phase: falling edge, present the next bit.
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            sclk_next     = 1'b0;
            mosi_next     = tx_shift_reg[7];
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
          end
        end else begin
          half_cnt_next = half_cnt_reg - 8'd1;
        end
      end

      HOLD: begin
        // Select stays asserted; a new byte continues on the same slave.
        if (tx_valid) begin
          state_next    = SETUP;
          tx_shift_next = tx_byte;
          last_next     = tx_last;
          mosi_next     = tx_byte[7];
          half_cnt_next = HALF_LOAD;
        end
      end

      GAP: begin
        // Both selects high for the minimum inactive time.
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // tx_ready depends on the state register only, so acceptance never
  // forms a combinational loop through tx_valid.
  assign tx_ready = (state_reg == IDLE) || (state_reg == HOLD);
  assign rx_valid = rx_valid_reg;
  assign rx_byte  = rx_byte_reg;
  assign busy     = busy_reg;
  assign sclk     = sclk_reg;
  assign mosi     = mosi_reg;
  assign ss1      = ss1_reg;
  assign ss2      = ss2_reg;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: default-parameter instance (a) and a
// fast instance (b, H=2, gap 0). Cycle n is counted from the accepting clock
// period (cycle 0); outputs are sampled at the falling clock edge.
module tb_spi_byte_master;

  logic clk = 1'b0;
  logic rst;

  logic       tx_valid_a = 1'b0, tx_last_a = 1'b0, tx_sel_a = 1'b0;
  logic [7:0] tx_byte_a = 8'h00;
  logic       tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, miso_a, ss1_a, ss2_a;
  logic [7:0] rx_byte_a;
  logic       loop_a = 1'b1, miso_drv_a = 1'b0;

  logic       tx_valid_b = 1'b0, tx_last_b = 1'b0, tx_sel_b = 1'b0;
  logic [7:0] tx_byte_b = 8'h00;
  logic       tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, miso_b, ss1_b, ss2_b;
  logic [7:0] rx_byte_b;

  int checks = 0;
  int errors = 0;

  assign miso_a = loop_a ? mosi_a : miso_drv_a;
  assign miso_b = mosi_b;

  always #5 clk = ~clk;

  spi_byte_master #(.CLKS_PER_HALF_BIT(4), .CS_INACTIVE_CLKS(10)) dut_a (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid_a), .tx_byte(tx_byte_a), .tx_last(tx_last_a), .tx_sel(tx_sel_a),
    .tx_ready(tx_ready_a), .rx_valid(rx_valid_a), .rx_byte(rx_byte_a), .busy(busy_a),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ss1(ss1_a), .ss2(ss2_a)
  );

  spi_byte_master #(.CLKS_PER_HALF_BIT(2), .CS_INACTIVE_CLKS(0)) dut_b (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid_b), .tx_byte(tx_byte_b), .tx_last(tx_last_b), .tx_sel(tx_sel_b),
    .tx_ready(tx_ready_b), .rx_valid(rx_valid_b), .rx_byte(rx_byte_b), .busy(busy_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ss1(ss1_b), .ss2(ss2_b)
  );

  // Reset levels on both instances while rst is held low.
  task automatic test_reset();
    logic [14:0] got_a;
    logic [4:0]  got_b;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    got_a = {ss1_a, ss2_a, sclk_a, mosi_a, tx_ready_a, busy_a, rx_valid_a, rx_byte_a};
    checks++;
    if (got_a !== 15'b111110_0_00000000) begin
      errors++;
      $display("FAIL reset_a: got %b expected %b", got_a, 15'b111110_0_00000000);
    end
    got_b = {ss1_b, ss2_b, sclk_b, tx_ready_b, busy_b};
    checks++;
    if (got_b !== 5'b11110) begin
      errors++;
      $display("FAIL reset_b: got %b expected %b", got_b, 5'b11110);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("reset: ss=%b%b sclk=%b ready=%b busy=%b", ss1_a, ss2_a, sclk_a, tx_ready_a, busy_a);
  endtask

  // 0xA5 to ss1 with loopback; full per-cycle timeline check.
  task automatic test_single_byte();
    logic [7:0] b;
    logic [5:0] got, exp;
    logic       exp_mosi;
    int         k;
    b = 8'hA5;
    loop_a = 1'b1;
    tx_byte_a = b; tx_sel_a = 1'b0; tx_last_a = 1'b1; tx_valid_a = 1'b1;
    checks++;
    if (tx_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL single_ready0: got %b expected 1", tx_ready_a);
    end
    for (int n = 1; n <= 82; n++) begin
      @(negedge clk);
      tx_valid_a = 1'b0;
      exp = {!(n <= 68), 1'b1, !(n >= 5 && n <= 64 && ((n - 5) % 8) < 4),
             (n == 69), (n >= 79), (n < 79)};
      got = {ss1_a, ss2_a, sclk_a, rx_valid_a, tx_ready_a, busy_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_c%0d ss1/ss2/sclk/rxv/rdy/busy: got %b expected %b", n, got, exp);
      end
      if (n <= 68) begin
        k = (n <= 4) ? 0 : (n - 5) / 8;
        exp_mosi = b[7 - k];
        checks++;
        if (mosi_a !== exp_mosi) begin
          errors++;
          $display("FAIL single_mosi_c%0d: got %b expected %b", n, mosi_a, exp_mosi);
        end
      end
      if (n == 69) begin
        checks++;
        if (rx_byte_a !== b) begin
          errors++;
          $display("FAIL single_rx: got %h expected %h", rx_byte_a, b);
        end
        $display("single: rx_valid cycle %0d rx_byte=%h", n, rx_byte_a);
      end
    end
  endtask

  // 0x3C (last=0) then 0xC3 (last=1) to ss2, offered back-to-back.
  task automatic test_burst();
    logic [15:0] bits;
    logic [4:0]  got, exp;
    logic        prev_sclk;
    int          nbits;
    bits = 16'h0; nbits = 0; prev_sclk = 1'b1;
    loop_a = 1'b1;
    tx_byte_a = 8'h3C; tx_sel_a = 1'b1; tx_last_a = 1'b0; tx_valid_a = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      exp = {1'b1, !(n <= 137), (n == 69 || n == 138), (n == 69 || n >= 148), (n < 148)};
      got = {ss1_a, ss2_a, rx_valid_a, tx_ready_a, busy_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL burst_c%0d ss1/ss2/rxv/rdy/busy: got %b expected %b", n, got, exp);
      end
      if (!prev_sclk && sclk_a) begin
        bits = {bits[14:0], mosi_a};
        nbits++;
      end
      prev_sclk = sclk_a;
      if (n == 69) begin
        checks++;
        if (rx_byte_a !== 8'h3C) begin
          errors++;
          $display("FAIL burst_rx1: got %h expected 3c", rx_byte_a);
        end
        $display("burst: byte1 rx_valid cycle %0d rx_byte=%h", n, rx_byte_a);
      end
      if (n == 138) begin
        checks++;
        if (rx_byte_a !== 8'hC3) begin
          errors++;
          $display("FAIL burst_rx2: got %h expected c3", rx_byte_a);
        end
        $display("burst: byte2 rx_valid cycle %0d rx_byte=%h", n, rx_byte_a);
      end
      // Second byte waits on tx_valid; tx_sel changes but must be ignored.
      if (n == 1) begin
        tx_byte_a = 8'hC3; tx_last_a = 1'b1; tx_sel_a = 1'b0;
      end
      if (n == 70) tx_valid_a = 1'b0;
    end
    checks++;
    if (bits !== 16'h3CC3 || nbits != 16) begin
      errors++;
      $display("FAIL burst_mosi: got %h (%0d bits) expected 3cc3 (16 bits)", bits, nbits);
    end
  endtask

  // tx_valid held high with tx_byte changing every cycle.
  task automatic test_held_valid();
    logic [7:0] second;
    logic [1:0] got, exp;
    loop_a = 1'b1;
    second = 8'(79 * 37 + 11);
    tx_byte_a = 8'h96; tx_sel_a = 1'b0; tx_last_a = 1'b1; tx_valid_a = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      exp = {(n == 69 || n == 148), (n == 79 || n >= 158)};
      got = {rx_valid_a, tx_ready_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL held_c%0d rxv/rdy: got %b expected %b", n, got, exp);
      end
      if (n == 69) begin
        checks++;
        if (rx_byte_a !== 8'h96) begin
          errors++;
          $display("FAIL held_rx1: got %h expected 96", rx_byte_a);
        end
        $display("held: byte1 rx_byte=%h", rx_byte_a);
      end
      if (n == 148) begin
        checks++;
        if (rx_byte_a !== second) begin
          errors++;
          $display("FAIL held_rx2: got %h expected %h", rx_byte_a, second);
        end
        $display("held: byte2 rx_byte=%h", rx_byte_a);
      end
      if (n <= 79) tx_byte_a = 8'(n * 37 + 11);
      else tx_valid_a = 1'b0;
    end
  endtask

  // miso held constant: independent of what is transmitted.
  task automatic test_miso_const();
    logic [7:0] txv [2];
    logic [7:0] rxe [2];
    logic       lvl [2];
    txv[0] = 8'h00; rxe[0] = 8'hFF; lvl[0] = 1'b1;
    txv[1] = 8'hFF; rxe[1] = 8'h00; lvl[1] = 1'b0;
    loop_a = 1'b0;
    for (int t = 0; t < 2; t++) begin
      miso_drv_a = lvl[t];
      tx_byte_a = txv[t]; tx_sel_a = 1'b0; tx_last_a = 1'b1; tx_valid_a = 1'b1;
      for (int n = 1; n <= 80; n++) begin
        @(negedge clk);
        tx_valid_a = 1'b0;
        if (n == 69) begin
          checks++;
          if (rx_valid_a !== 1'b1 || rx_byte_a !== rxe[t]) begin
            errors++;
            $display("FAIL miso_const%0d: got rxv=%b rx=%h expected rxv=1 rx=%h",
                     t, rx_valid_a, rx_byte_a, rxe[t]);
          end
          $display("miso=%b tx=%h: rx_byte=%h", lvl[t], txv[t], rx_byte_a);
        end
      end
    end
    loop_a = 1'b1;
  endtask

  // rst pulsed at cycle 30, then a fresh byte accepted straight after.
  task automatic test_reset_mid();
    logic [6:0] got;
    logic [3:0] g2, e2;
    loop_a = 1'b1;
    tx_byte_a = 8'h5A; tx_sel_a = 1'b0; tx_last_a = 1'b1; tx_valid_a = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      tx_valid_a = 1'b0;
    end
    rst = 1'b0;
    #1;
    got = {ss1_a, ss2_a, sclk_a, mosi_a, busy_a, tx_ready_a, rx_valid_a};
    checks++;
    if (got !== 7'b1111010) begin
      errors++;
      $display("FAIL rstmid_async ss1/ss2/sclk/mosi/busy/rdy/rxv: got %b expected 1111010", got);
    end
    checks++;
    if (rx_byte_a !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_rxbyte: got %h expected 00", rx_byte_a);
    end
    $display("rstmid: reset at cycle 30 ss1=%b sclk=%b busy=%b", ss1_a, sclk_a, busy_a);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rx_valid_a !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_norxv: got %b expected 0", rx_valid_a);
      end
    end
    rst = 1'b1;
    tx_byte_a = 8'hE7; tx_sel_a = 1'b1; tx_last_a = 1'b1; tx_valid_a = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      tx_valid_a = 1'b0;
      e2 = {1'b1, !(n <= 68), (n == 69), (n >= 79)};
      g2 = {ss1_a, ss2_a, rx_valid_a, tx_ready_a};
      checks++;
      if (g2 !== e2) begin
        errors++;
        $display("FAIL rstmid_c%0d ss1/ss2/rxv/rdy: got %b expected %b", n, g2, e2);
      end
      if (n == 69) begin
        checks++;
        if (rx_byte_a !== 8'hE7) begin
          errors++;
          $display("FAIL rstmid_rx: got %h expected e7", rx_byte_a);
        end
        $display("rstmid: new byte rx_byte=%h", rx_byte_a);
      end
    end
  endtask

  // H=2, gap 0: rx_valid at 35, one GAP cycle, ready at 36.
  task automatic test_fast();
    logic [5:0] got, exp;
    tx_byte_b = 8'hC6; tx_sel_b = 1'b0; tx_last_b = 1'b1; tx_valid_b = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      tx_valid_b = 1'b0;
      exp = {!(n <= 34), 1'b1, !(n >= 3 && n <= 32 && ((n - 3) % 4) < 2),
             (n == 35), (n >= 36), (n < 36)};
      got = {ss1_b, ss2_b, sclk_b, rx_valid_b, tx_ready_b, busy_b};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fast_c%0d ss1/ss2/sclk/rxv/rdy/busy: got %b expected %b", n, got, exp);
      end
      if (n == 35) begin
        checks++;
        if (rx_byte_b !== 8'hC6) begin
          errors++;
          $display("FAIL fast_rx: got %h expected c6", rx_byte_b);
        end
        $display("fast: rx_valid cycle %0d rx_byte=%h", n, rx_byte_b);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_byte();
    @(negedge clk);
    test_burst();
    @(negedge clk);
    test_held_valid();
    @(negedge clk);
    test_miso_const();
    @(negedge clk);
    test_reset_mid();
    @(negedge clk);
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Byte-oriented SPI master engine (mode 3: CPOL=1, CPHA=1) that sits directly downstream of the 68000 glue logic's SPI register file. The glue logic hands it one byte at a time with a valid/ready handshake. The engine shifts the byte out MSB-first on MOSI while capturing MISO, drives one of two slave selects, and returns the received byte with a one-cycle strobe. Slave select can be held across consecutive bytes for multi-byte transactions.

## Interface
- CLKS_PER_HALF_BIT, 4, clk cycles per SCLK half period (H); legal range 2..255
- CS_INACTIVE_CLKS, 10, minimum clk cycles both selects stay high after a transaction ends; 0 is treated as 1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- tx_valid  in  1  byte offered
- tx_byte  in  8  byte to transmit, sampled on acceptance
- tx_last  in  1  sampled on acceptance; 1 = release select after this byte
- tx_sel  in  1  sampled on acceptance from IDLE only; 0 = ss1, 1 = ss2
- tx_ready  out  1  engine can accept a byte this cycle
- rx_valid  out  1  one-cycle strobe: rx_byte updated
- rx_byte  out  8  last received byte, held until next strobe
- busy  out  1  high in every state except IDLE
- sclk  out  1  SPI clock, idles high
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- ss1  out  1  slave select 1, active low
- ss2  out  1  slave select 2, active low

## Operation
- Acceptance: tx_valid & tx_ready at a rising edge.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: tx_ready=1, both selects high, sclk=1, mosi=1.
  - On accept: latch tx_byte, tx_last and tx_sel, then go to SETUP.
- SETUP: lasts H cycles.
  - The selected ss is low and mosi = bit7.
  - Then go to SHIFT.
- SHIFT: 8 bit periods of 2H cycles each, MSB first.
  - Each period: sclk low for H cycles, then high for H cycles.
  - mosi is updated to the current bit on the register update that drives sclk low (falling edge).
  - miso is sampled on the register update that drives sclk high (rising edge).
  - The first sampled bit lands in rx bit7.
- After the 8th high phase, rx_byte is loaded and rx_valid=1 for one cycle.
  - The next state is HOLD if the latched tx_last=0, otherwise GAP.
- HOLD: select stays low, sclk=1, mosi holds the last bit, tx_ready=1.
  - On accept: latch tx_byte and tx_last, go to SETUP.
  - tx_sel is ignored in HOLD; the same slave stays selected.
  - There is no timeout; only reset or a byte with tx_last=1 releases the select.
- GAP: both selects high, tx_ready=0, for max(CS_INACTIVE_CLKS,1) cycles, then IDLE.
- tx_valid while tx_ready=0 is ignored and causes no side effect.
- Arithmetic and width rules:
  - Half-bit counter is 8 bits and reloads to H-1.
  - Bit counter is 3 bits.
  - Gap counter is at least 8 bits wide.
  - The shift registers are two separate 8-bit registers (TX and RX).

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs, except tx_ready, which is decoded from state only.
- Reset values (asynchronous, while rst=0):
  - State = IDLE.
  - ss1=ss2=1, sclk=1, mosi=1.
  - tx_ready=1, busy=0.
  - rx_valid=0, rx_byte=8'h00.
  - All counters cleared.
- Reset mid-transfer: outputs return to their reset values immediately.
  - No rx_valid is issued for the aborted byte.
  - No GAP is enforced after reset.
- Per-byte timeline, with acceptance at cycle 0:
  - Cycles 1..H: SETUP, select low.
  - Bit k sclk low phase: cycles 1+H+2Hk .. 2H+2Hk.
  - Bit k sclk high phase: the next H cycles.
  - rx_valid: cycle 1+17H, which is 69 for H=4.
- With tx_last=1, the select deasserts at cycle 1+17H.
  - tx_ready rises at cycle 1+17H+max(CS_INACTIVE_CLKS,1), which is 79 for defaults.
- With tx_last=0, tx_ready=1 from cycle 1+17H, the same cycle as rx_valid.
  - A byte accepted in that cycle starts SETUP at 2+17H.
  - The minimum byte-to-byte spacing in a burst is therefore 1+17H cycles.
- busy is high from cycle 1 until the cycle IDLE is re-entered.

## Test plan
- Single byte, defaults: tx_byte=0xA5, tx_sel=0, tx_last=1, miso looped from mosi.
  - ss1 low for cycles 1..68, ss2 stays high.
  - Exactly 8 sclk low pulses of 4 cycles each.
  - rx_valid at cycle 69 with rx_byte=0xA5.
  - tx_ready returns at cycle 79.
- Two-byte burst to ss2: 0x3C with tx_last=0, then 0xC3 with tx_last=1, offered back-to-back.
  - ss2 stays low continuously across both bytes; ss1 stays high.
  - Second acceptance at cycle 69; two rx_valid strobes.
  - mosi bit sequence is 0x3C then 0xC3.
- miso held 1 with tx 0x00 returns rx_byte=0xFF; miso held 0 with tx 0xFF returns 0x00.
- tx_valid held high throughout a transfer with changing tx_byte:
  - Only the bytes present in acceptance cycles are sent.
  - No acceptance occurs while tx_ready=0.
- rst pulsed low at cycle 30 of a transfer:
  - ss1, sclk and mosi go high immediately; busy=0; no rx_valid.
  - A new byte accepted right after reset completes normally.
- CLKS_PER_HALF_BIT=2, CS_INACTIVE_CLKS=0, single byte:
  - rx_valid at cycle 35.
  - GAP lasts 1 cycle; tx_ready returns at cycle 36.
